// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, reply bytes, FSM states and helpers
// for the UART command responder.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] OP_PING = 8'h50;

  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_RD_WAIT,
    ST_SEND
  } state_t;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_responder_if.sv
// FIFO and register-bus signals of the command responder.
// master: responder side; slave: FIFO/bus environment side.
interface uart_cmd_responder_if;

  logic       rx_fifo_empty;
  logic [7:0] rx_fifo_data_out;
  logic       rx_fifo_read_en;
  logic       tx_fifo_full;
  logic [7:0] tx_fifo_data_in;
  logic       tx_fifo_write_en;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;

  modport master (
    input  rx_fifo_empty, rx_fifo_data_out,
    input  tx_fifo_full, bus_rdata,
    output rx_fifo_read_en, tx_fifo_data_in,
    output tx_fifo_write_en, bus_addr,
    output bus_wdata, bus_we, bus_re
  );

  modport slave (
    output rx_fifo_empty, rx_fifo_data_out,
    output tx_fifo_full, bus_rdata,
    input  rx_fifo_read_en, tx_fifo_data_in,
    input  tx_fifo_write_en, bus_addr,
    input  bus_wdata, bus_we, bus_re
  );

endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timer: clears on i_clear, counts while i_run,
// o_expire holds once TIMEOUT_CYCLES is reached.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 270000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear)
      r_cnt <= '0;
    else if (i_run && !o_expire)
      r_cnt <= r_cnt + W'(1);
  end

  assign o_expire = (r_cnt == LIMIT);

endmodule

// File: rtl/uart_cmd_responder.sv
// Decodes W/R/P command frames from the UART RX FIFO into
// register-bus accesses and pushes a one-byte reply.
// Ports: clock, reset (sync, active-high), io (master
// modport: RX/TX FIFO + 8-bit register bus), busy,
// err_count (saturating count of '?' replies).
// Optional: UART_CMD_TIMEOUT_EN adds an inter-byte abort.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 270000,
  parameter logic [7:0] VERSION        = 8'h01
) (
  input  logic                        clock,
  input  logic                        reset,
  uart_cmd_responder_if.master        io,
  output logic                        busy,
  output logic [7:0]                  err_count
);

  state_t     r_state;
  logic       r_gap;
  logic       r_is_wr;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_reply;
  logic [7:0] r_err;
  logic       r_we;
  logic       r_re;

  logic w_in_get;
  logic w_accept;
  logic w_timeout;

  assign w_in_get = (r_state == ST_GET_ADDR) ||
                    (r_state == ST_GET_DATA);

  // Gated by reset so a pop can never be lost while the
  // FSM is being cleared; r_gap blocks back-to-back pops
  // against the registered empty flag.
  assign w_accept = !reset && !r_gap &&
                    !io.rx_fifo_empty &&
                    ((r_state == ST_IDLE) || w_in_get);

`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_clear  (w_accept || !w_in_get),
    .i_run    (w_in_get),
    .o_expire (w_timeout)
  );
`else
  // Timer compiled out: frames wait forever.
  assign w_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_gap   <= 1'b0;
      r_is_wr <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
      r_reply <= 8'h00;
      r_err   <= 8'h00;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
    end else begin
      r_gap <= w_accept;
      r_we  <= 1'b0;
      r_re  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            unique case (1'b1)
              (io.rx_fifo_data_out == OP_WR): begin
                r_is_wr <= 1'b1;
                r_state <= ST_GET_ADDR;
              end
              (io.rx_fifo_data_out == OP_RD): begin
                r_is_wr <= 1'b0;
                r_state <= ST_GET_ADDR;
              end
              (io.rx_fifo_data_out == OP_PING): begin
                r_reply <= VERSION;
                r_state <= ST_SEND;
              end
              default: begin
                r_reply <= RSP_ERR;
                r_err   <= sat_inc8(r_err);
                r_state <= ST_SEND;
              end
            endcase
          end
        end
        ST_GET_ADDR: begin
          if (w_accept) begin
            r_addr <= io.rx_fifo_data_out;
            if (r_is_wr) begin
              r_state <= ST_GET_DATA;
            end else begin
              r_re    <= 1'b1;
              r_state <= ST_BUS_RD;
            end
          end else if (w_timeout) begin
            r_reply <= RSP_ERR;
            r_err   <= sat_inc8(r_err);
            r_state <= ST_SEND;
          end
        end
        ST_GET_DATA: begin
          if (w_accept) begin
            r_wdata <= io.rx_fifo_data_out;
            r_we    <= 1'b1;
            r_state <= ST_BUS_WR;
          end else if (w_timeout) begin
            r_reply <= RSP_ERR;
            r_err   <= sat_inc8(r_err);
            r_state <= ST_SEND;
          end
        end
        ST_BUS_WR: begin
          r_reply <= RSP_OK;
          r_state <= ST_SEND;
        end
        ST_BUS_RD: begin
          r_state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          r_reply <= io.bus_rdata;
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (!io.tx_fifo_full)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Push is combinational on tx_fifo_full so it lands in
  // the first non-full cycle of SEND.
  assign io.rx_fifo_read_en  = w_accept;
  assign io.tx_fifo_write_en = (r_state == ST_SEND) &&
                               !io.tx_fifo_full;
  assign io.tx_fifo_data_in  = r_reply;
  assign io.bus_addr         = r_addr;
  assign io.bus_wdata        = r_wdata;
  assign io.bus_we           = r_we;
  assign io.bus_re           = r_re;
  assign busy                = (r_state != ST_IDLE);
  assign err_count           = r_err;

endmodule
